// File: rtl/radar_dsp_pkg.sv
// radar_dsp_pkg: shared FSM state, widths and helpers for the FFT chain.
// The Hann ROM constant is present only when FFT_WINDOW_EN is defined.
package radar_dsp_pkg;

  localparam int DEF_DATA_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ARM,
    FEED,
    WAIT,
    DRAIN
  } fsm_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

`ifdef FFT_WINDOW_EN
  // Half of a 64-point Hann window, unsigned Q1.15, w[n] = w[64-n].
  localparam logic [15:0] HANN_HALF [33] = '{
    16'd0,     16'd79,    16'd315,   16'd705,
    16'd1247,  16'd1935,  16'd2761,  16'd3719,
    16'd4799,  16'd5990,  16'd7282,  16'd8661,
    16'd10114, 16'd11628, 16'd13188, 16'd14778,
    16'd16384, 16'd17990, 16'd19580, 16'd21140,
    16'd22654, 16'd24107, 16'd25486, 16'd26778,
    16'd27969, 16'd29049, 16'd30007, 16'd30833,
    16'd31521, 16'd32063, 16'd32453, 16'd32689,
    16'd32768
  };

  // Other lengths reuse the 64-point table at the nearest phase.
  function automatic logic [15:0] hann_q15(
    input int n,
    input int len
  );
    int p;
    p = (n * 64) / len;
    if (p > 32) p = 64 - p;
    return HANN_HALF[p];
  endfunction
`endif

endpackage

// File: rtl/fft_peak_tracker.sv
// fft_peak_tracker: per-frame maximum over the non-mirrored bins of the
// magnitude stream; the lower bin wins a tie.
module fft_peak_tracker
  import radar_dsp_pkg::*;
#(
  parameter int FFT_LEN = 64,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MIN_BIN = 1,
  localparam int AW     = clog2(FFT_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  input  logic [AW-1:0]     m_bin,
  input  logic [DATA_W-1:0] m_mag1,
  input  logic [DATA_W-1:0] m_mag2,
  input  logic              m_last,
  output logic              peak_valid,
  output logic [AW-1:0]     peak_bin,
  output logic [DATA_W-1:0] peak_mag,
  output logic [15:0]       frame_cnt
);

  logic              have, have_nx;
  logic [AW-1:0]     best_bin, bin_nx;
  logic [DATA_W-1:0] best_mag, mag_nx;
  logic [AW-1:0]     bin2;
  logic              ok1, ok2;

  assign bin2 = m_bin | AW'(1);
  assign ok1  = int'(m_bin) >= MIN_BIN
             && int'(m_bin) < FFT_LEN / 2;
  assign ok2  = int'(bin2) >= MIN_BIN
             && int'(bin2) < FFT_LEN / 2;

  // mag1 is folded in before mag2, strict compare keeps the lower bin.
  always_comb begin
    have_nx = have;
    bin_nx  = best_bin;
    mag_nx  = best_mag;
    if (ok1 && (!have_nx || m_mag1 > mag_nx)) begin
      have_nx = 1'b1;
      bin_nx  = m_bin;
      mag_nx  = m_mag1;
    end
    if (ok2 && (!have_nx || m_mag2 > mag_nx)) begin
      have_nx = 1'b1;
      bin_nx  = bin2;
      mag_nx  = m_mag2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      have       <= 1'b0;
      best_bin   <= '0;
      best_mag   <= '0;
      peak_valid <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
      frame_cnt  <= '0;
    end else begin
      peak_valid <= 1'b0;
      if (m_valid && m_last) begin
        have       <= 1'b0;
        peak_valid <= 1'b1;
        peak_bin   <= bin_nx;
        peak_mag   <= mag_nx;
        frame_cnt  <= frame_cnt + 1'b1;
      end else if (m_valid) begin
        have     <= have_nx;
        best_bin <= bin_nx;
        best_mag <= mag_nx;
      end
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frame buffer and sequencer around dft_top + magnitude.
// Define FFT_WINDOW_EN to apply a Hann window while feeding the FFT.
module fft_frame_ctrl
  import radar_dsp_pkg::*;
#(
  parameter int FFT_LEN = 64,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MIN_BIN = 1,
  parameter int TIMEOUT = 4096,
  localparam int AW     = clog2(FFT_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              fft_next,
  output logic [DATA_W-1:0] fft_x0,
  output logic [DATA_W-1:0] fft_x1,
  output logic [DATA_W-1:0] fft_x2,
  output logic [DATA_W-1:0] fft_x3,
  input  logic              fft_next_out,
  input  logic [DATA_W-1:0] fft_mag1,
  input  logic [DATA_W-1:0] fft_mag2,
  output logic              m_valid,
  output logic [AW-1:0]     m_bin,
  output logic [DATA_W-1:0] m_mag1,
  output logic [DATA_W-1:0] m_mag2,
  output logic              m_last,
  output logic              peak_valid,
  output logic [AW-1:0]     peak_bin,
  output logic [DATA_W-1:0] peak_mag,
  output logic [15:0]       frame_cnt,
  output logic              err_timeout
);

  localparam int HW   = AW - 1;
  localparam int HALF = FFT_LEN / 2;
  localparam int CMAX = (TIMEOUT > FFT_LEN) ? TIMEOUT : FFT_LEN;
  localparam int CW   = clog2(CMAX + 1);
`ifdef FFT_WINDOW_EN
  localparam int ARM_CYC = 2;
`else
  localparam int ARM_CYC = 1;
`endif

  fsm_state_t        state, state_nx;
  logic [CW-1:0]     cnt;
  logic              fill_done, arm_done, last_pair, wait_tmo;
  logic              wr_en, rd_en, feed;
  logic [HW-1:0]     rd_addr;
  logic [DATA_W-1:0] mem_e [HALF];
  logic [DATA_W-1:0] mem_o [HALF];
  logic [DATA_W-1:0] rd_e, rd_o;
  logic [DATA_W-1:0] x_e, x_o;

  assign fill_done = s_valid && cnt == CW'(FFT_LEN - 1);
  assign arm_done  = cnt == CW'(ARM_CYC - 1);
  assign last_pair = cnt == CW'(HALF - 1);
  assign wait_tmo  = cnt == CW'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (run) state_nx = FILL;
      FILL:  if (fill_done) state_nx = ARM;
      ARM:   if (arm_done) state_nx = FEED;
      FEED:  if (last_pair) state_nx = WAIT;
      WAIT: begin
        if (fft_next_out)  state_nx = DRAIN;
        else if (wait_tmo) state_nx = IDLE;
      end
      DRAIN: if (last_pair) state_nx = run ? FILL : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    s_ready  = state == FILL;
    wr_en    = state == FILL && s_valid;
    rd_en    = state == ARM || state == FEED;
    feed     = state == FEED;
    fft_next = state == ARM && arm_done;
  end

  // One counter serves fill index, arm/feed/drain step and wait time.
  always_ff @(posedge clk) begin
    if (reset || state_nx != state)
      cnt <= '0;
    else if (state != IDLE && (state != FILL || s_valid))
      cnt <= cnt + 1'b1;
  end

  // Read runs ARM_CYC pairs ahead so data lines up after fft_next.
  assign rd_addr = feed ? HW'(cnt) + HW'(ARM_CYC) : HW'(cnt);

  always_ff @(posedge clk) begin
    if (wr_en && !cnt[0]) mem_e[cnt[AW-1:1]] <= s_data;
    if (wr_en &&  cnt[0]) mem_o[cnt[AW-1:1]] <= s_data;
    if (rd_en) begin
      rd_e <= mem_e[rd_addr];
      rd_o <= mem_o[rd_addr];
    end
  end

`ifdef FFT_WINDOW_EN
  localparam int PW = DATA_W + 17;

  logic [HW-1:0]        rd_addr_q;
  logic [15:0]          c_e, c_o;
  logic signed [PW-1:0] p_e, p_o;

  always_ff @(posedge clk)
    if (rd_en) rd_addr_q <= rd_addr;

  always_comb begin
    c_e = hann_q15(2 * int'(rd_addr_q), FFT_LEN);
    c_o = hann_q15(2 * int'(rd_addr_q) + 1, FFT_LEN);
  end

  assign p_e = $signed(rd_e) * $signed({1'b0, c_e})
             + PW'(16384);
  assign p_o = $signed(rd_o) * $signed({1'b0, c_o})
             + PW'(16384);

  always_ff @(posedge clk)
    if (rd_en) begin
      x_e <= p_e[DATA_W+14:15];
      x_o <= p_o[DATA_W+14:15];
    end
`else
  assign x_e = rd_e;
  assign x_o = rd_o;
`endif

  assign fft_x0 = feed ? x_e : '0;
  assign fft_x1 = '0;
  assign fft_x2 = feed ? x_o : '0;
  assign fft_x3 = '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_bin   <= '0;
      m_mag1  <= '0;
      m_mag2  <= '0;
    end else begin
      m_valid <= state == DRAIN;
      m_last  <= state == DRAIN && last_pair;
      if (state == DRAIN) begin
        m_bin  <= {cnt[HW-1:0], 1'b0};
        m_mag1 <= fft_mag1;
        m_mag2 <= fft_mag2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      err_timeout <= 1'b0;
    else if (state == WAIT && !fft_next_out && wait_tmo)
      err_timeout <= 1'b1;
  end

  fft_peak_tracker #(
    .FFT_LEN (FFT_LEN),
    .DATA_W  (DATA_W),
    .MIN_BIN (MIN_BIN)
  ) u_peak (
    .clk        (clk),
    .reset      (reset),
    .m_valid    (m_valid),
    .m_bin      (m_bin),
    .m_mag1     (m_mag1),
    .m_mag2     (m_mag2),
    .m_last     (m_last),
    .peak_valid (peak_valid),
    .peak_bin   (peak_bin),
    .peak_mag   (peak_mag),
    .frame_cnt  (frame_cnt)
  );

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: random and directed frames against a DFT/peak model
// that plays the role of dft_top + magnitude.
module tb_fft_frame_ctrl;

  localparam int  N    = 64;
  localparam int  H    = N / 2;
  localparam int  DW   = 12;
  localparam int  MINB = 1;
  localparam int  TMO  = 100;
  localparam real PI   = 3.14159265358979;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          fft_next;
  logic [DW-1:0] fft_x0, fft_x1, fft_x2, fft_x3;
  logic          fft_next_out = 1'b0;
  logic [DW-1:0] fft_mag1 = '0;
  logic [DW-1:0] fft_mag2 = '0;
  logic          m_valid;
  logic [5:0]    m_bin;
  logic [DW-1:0] m_mag1, m_mag2;
  logic          m_last;
  logic          peak_valid;
  logic [5:0]    peak_bin;
  logic [DW-1:0] peak_mag;
  logic [15:0]   frame_cnt;
  logic          err_timeout;

  fft_frame_ctrl #(
    .FFT_LEN (N),
    .DATA_W  (DW),
    .MIN_BIN (MINB),
    .TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .fft_next     (fft_next),
    .fft_x0       (fft_x0),
    .fft_x1       (fft_x1),
    .fft_x2       (fft_x2),
    .fft_x3       (fft_x3),
    .fft_next_out (fft_next_out),
    .fft_mag1     (fft_mag1),
    .fft_mag2     (fft_mag2),
    .m_valid      (m_valid),
    .m_bin        (m_bin),
    .m_mag1       (m_mag1),
    .m_mag2       (m_mag2),
    .m_last       (m_last),
    .peak_valid   (peak_valid),
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag),
    .frame_cnt    (frame_cnt),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int bin;
    int m1;
    int m2;
    int last;
    int cyc;
  } pair_t;

  pair_t pq[$];
  int    pk_bin_q[$];
  int    pk_mag_q[$];
  int    pk_cnt_q[$];
  int    pk_cyc_q[$];
  int    nxt_cnt = 0;
  int    cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (m_valid)
      pq.push_back('{int'(m_bin), int'(m_mag1), int'(m_mag2),
                     int'(m_last), cyc});
    if (peak_valid) begin
      pk_bin_q.push_back(int'(peak_bin));
      pk_mag_q.push_back(int'(peak_mag));
      pk_cnt_q.push_back(int'(frame_cnt));
      pk_cyc_q.push_back(cyc);
    end
    if (fft_next) nxt_cnt++;
  end

  int samp[N];
  int cap[N];
  int mags[N];
  int exp_frames = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_samples(input int mode);
    for (int n = 0; n < N; n++) begin
      case (mode)
        0: samp[n] = int'(1000.0 * $cos(2.0 * PI * 5.0 * n / N));
        1: samp[n] = int'(500.0
                     + 800.0 * $cos(2.0 * PI * 12.0 * n / N));
        default: samp[n] = int'($urandom_range(0, 4095)) - 2048;
      endcase
    end
  endtask

  // Magnitude model: |X[k]| / 32 of the words the FFT actually received.
  task automatic gen_mags(input int mode);
    real re, im, a;
    for (int k = 0; k < N; k++) begin
      case (mode)
        0: begin
          re = 0.0;
          im = 0.0;
          for (int n = 0; n < N; n++) begin
            a  = 2.0 * PI * k * n / N;
            re = re + cap[n] * $cos(a);
            im = im - cap[n] * $sin(a);
          end
          mags[k] = int'($sqrt(re * re + im * im) / 32.0);
          if (mags[k] > 4095) mags[k] = 4095;
        end
        1: mags[k] = (k == 3 || k == 7) ? 300 : 0;
        2: mags[k] = int'($urandom_range(0, 15));
        default: mags[k] = int'($urandom_range(0, 4095));
      endcase
    end
  endtask

  task automatic exp_peak(output int b, output int m);
    b = 0;
    m = 0;
    for (int i = MINB; i < H; i++)
      if (i == MINB || mags[i] > m) begin
        b = i;
        m = mags[i];
      end
  endtask

  task automatic out_zero(input string nm);
    chk({nm, " s_ready"}, int'(s_ready), 0);
    chk({nm, " fft_next"}, int'(fft_next), 0);
    chk({nm, " fft_x0"}, int'(fft_x0), 0);
    chk({nm, " fft_x2"}, int'(fft_x2), 0);
    chk({nm, " m_valid"}, int'(m_valid), 0);
    chk({nm, " m_bin"}, int'(m_bin), 0);
    chk({nm, " m_mag1"}, int'(m_mag1), 0);
    chk({nm, " m_last"}, int'(m_last), 0);
    chk({nm, " peak_valid"}, int'(peak_valid), 0);
    chk({nm, " peak_bin"}, int'(peak_bin), 0);
    chk({nm, " peak_mag"}, int'(peak_mag), 0);
    chk({nm, " frame_cnt"}, int'(frame_cnt), 0);
    chk({nm, " err_timeout"}, int'(err_timeout), 0);
  endtask

  task automatic do_reset(input string nm);
    reset        = 1'b1;
    run          = 1'b0;
    s_valid      = 1'b0;
    fft_next_out = 1'b0;
    fft_mag1     = '0;
    fft_mag2     = '0;
    tick();
    out_zero(nm);
    tick();
    reset      = 1'b0;
    exp_frames = 0;
  endtask

  task automatic idle_check(input string nm);
    int bad;
    bad = 0;
    for (int j = 0; j < 6; j++) begin
      if (s_ready || fft_next || m_valid) bad++;
      tick();
    end
    chk({nm, " stays idle"}, bad, 0);
  endtask

  task automatic do_frame(
    input int    smode,
    input int    mmode,
    input bit    gappy,
    input bit    drop_run,
    input bit    no_out,
    input int    abort_k,
    input string nm
  );
    int i, guard, bad, lat, eb, em, n0;
    bit acc, ph;
    gen_samples(smode);
    pq.delete();
    pk_bin_q.delete();
    pk_mag_q.delete();
    pk_cnt_q.delete();
    pk_cyc_q.delete();
    n0    = nxt_cnt;
    run   = 1'b1;
    i     = 0;
    guard = 0;
    ph    = 1'b0;
    while (i < N && guard < 1000) begin
      ph      = ~ph;
      s_valid = gappy ? ph : 1'b1;
      s_data  = DW'(samp[i]);
      acc     = s_valid && s_ready;
      tick();
      if (acc) i++;
      guard++;
    end
    s_valid = 1'b0;
    chk({nm, " samples accepted"}, i, N);
    guard = 0;
    while (!fft_next && guard < 8) begin
      tick();
      guard++;
    end
    chk({nm, " fft_next seen"}, int'(fft_next), 1);
    bad = 0;
    for (int k = 0; k < H; k++) begin
      tick();
      if (k == abort_k) begin
        reset = 1'b1;
        run   = 1'b0;
        return;
      end
      if (fft_next) bad++;
      if (fft_x1 != '0 || fft_x3 != '0) bad++;
      cap[2*k]   = int'($signed(fft_x0));
      cap[2*k+1] = int'($signed(fft_x2));
      if (cap[2*k] != samp[2*k]) bad++;
      if (cap[2*k+1] != samp[2*k+1]) bad++;
    end
    chk({nm, " feed stream"}, bad, 0);
    tick();
    if (no_out) return;
    gen_mags(mmode);
    lat = int'($urandom_range(1, 20));
    bad = 0;
    for (int j = 0; j < lat; j++) begin
      if (s_ready) bad++;
      tick();
    end
    fft_next_out = 1'b1;
    tick();
    fft_next_out = 1'b0;
    for (int k = 0; k < H; k++) begin
      fft_mag1 = DW'(mags[2*k]);
      fft_mag2 = DW'(mags[2*k+1]);
      if (drop_run && k == H / 2) run = 1'b0;
      if (s_ready) bad++;
      tick();
    end
    fft_mag1 = '0;
    fft_mag2 = '0;
    chk({nm, " s_ready low"}, bad, 0);
    repeat (3) tick();
    chk({nm, " pair count"}, pq.size(), H);
    bad = 0;
    foreach (pq[k]) begin
      if (k < H) begin
        if (pq[k].bin != 2 * k) bad++;
        if (pq[k].m1 != mags[2*k]) bad++;
        if (pq[k].m2 != mags[2*k+1]) bad++;
        if (pq[k].last != int'(k == H - 1)) bad++;
      end
    end
    chk({nm, " pair content"}, bad, 0);
    chk({nm, " fft_next pulses"}, nxt_cnt - n0, 1);
    chk({nm, " peak pulses"}, pk_bin_q.size(), 1);
    exp_peak(eb, em);
    exp_frames++;
    if (pk_bin_q.size() == 1 && pq.size() > 0) begin
      chk({nm, " peak_bin"}, pk_bin_q[0], eb);
      chk({nm, " peak_mag"}, pk_mag_q[0], em);
      chk({nm, " frame_cnt"}, pk_cnt_q[0], exp_frames);
      chk({nm, " peak timing"}, pk_cyc_q[0] - pq[pq.size()-1].cyc, 1);
    end
    chk({nm, " peak_bin held"}, int'(peak_bin), eb);
  endtask

  initial begin
    int bad;
    do_reset("reset");

    do_frame(0, 0, 1'b0, 1'b1, 1'b0, -1, "tone");
    chk("tone bin 5", int'(peak_bin), 5);
    chk("tone frame_cnt", int'(frame_cnt), 1);
    idle_check("tone");

    do_frame(1, 0, 1'b0, 1'b1, 1'b0, -1, "dc_tone");
    chk("dc_tone bin 12", int'(peak_bin), 12);

    do_frame(2, 1, 1'b0, 1'b1, 1'b0, -1, "tie");
    chk("tie bin", int'(peak_bin), 3);
    chk("tie mag", int'(peak_mag), 300);

    do_frame(2, 2, 1'($urandom_range(0, 1)), 1'b1, 1'b0, -1, "rnd_small");
    do_frame(2, 3, 1'b0, 1'b1, 1'b0, -1, "rnd_full");

    do_reset("reset2");
    for (int f = 0; f < 3; f++)
      do_frame(2, 0, 1'b1, f == 2, 1'b0, -1, "gappy");
    chk("gappy frame_cnt", int'(frame_cnt), 3);
    idle_check("gappy");

    do_frame(2, 0, 1'b0, 1'b0, 1'b1, -1, "tmo");
    run = 1'b0;
    chk("tmo wait1 err", int'(err_timeout), 0);
    bad = 0;
    for (int j = 2; j <= TMO; j++) begin
      tick();
      if (err_timeout) bad++;
    end
    chk("tmo err early", bad, 0);
    tick();
    chk("tmo err set", int'(err_timeout), 1);
    chk("tmo no pairs", pq.size(), 0);
    chk("tmo no peak", pk_bin_q.size(), 0);
    idle_check("tmo");
    do_frame(0, 0, 1'b0, 1'b1, 1'b0, -1, "post_tmo");
    chk("tmo err sticky", int'(err_timeout), 1);
    do_reset("reset3");

    do_frame(0, 0, 1'b0, 1'b1, 1'b0, -1, "pre_abort");
    do_frame(0, 0, 1'b0, 1'b1, 1'b0, 10, "abort");
    tick();
    out_zero("midfeed");
    reset      = 1'b0;
    exp_frames = 0;
    chk("abort no peak", pk_bin_q.size(), 0);
    do_frame(0, 0, 1'b0, 1'b1, 1'b0, -1, "fresh");
    chk("fresh bin 5", int'(peak_bin), 5);
    chk("fresh frame_cnt", int'(frame_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
- Frame sequencer for the FFT_Mag datapath (dft_top plus magnitude) in the FMCW radar DSP chain.
- Collects one chirp's worth of real ADC samples into a frame buffer, then bursts it into the streaming FFT with the required `next` framing.
- Waits for `next_out`, re-emits the magnitude spectrum as an indexed bin stream, and reports the peak (beat-frequency) bin per frame.

Parameters:
- FFT_LEN, 64: FFT points per frame; power of two, 8..1024. Feed and drain each take FFT_LEN/2 cycles (2 samples per cycle).
- DATA_W, 12: sample, FFT word and magnitude width.
- MIN_BIN, 1: lowest bin eligible for peak search; excludes DC leakage.
- TIMEOUT, 4096: maximum cycles allowed in WAIT before an error is flagged.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  level; while high, frames are acquired back to back
- s_valid  in  1  ADC sample valid
- s_data  in  DATA_W  signed ADC sample
- s_ready  out  1  sample accepted when s_valid&s_ready
- fft_next  out  1  start pulse to dft_top
- fft_x0, fft_x1, fft_x2, fft_x3  out  DATA_W each  FFT inputs: x0=re(2k), x1=im(2k)=0, x2=re(2k+1), x3=im(2k+1)=0
- fft_next_out  in  1  dft_top output-frame marker
- fft_mag1, fft_mag2  in  DATA_W each  magnitude of bin 2k, 2k+1
- m_valid  out  1  bin pair valid
- m_bin  out  log2(FFT_LEN)  index of mag1 bin (always even)
- m_mag1, m_mag2  out  DATA_W each  registered magnitudes
- m_last  out  1  final pair of frame
- peak_valid  out  1  one-cycle pulse, peak result ready
- peak_bin  out  log2(FFT_LEN)  bin of maximum magnitude
- peak_mag  out  DATA_W  maximum magnitude
- frame_cnt  out  16  completed frames, wraps at 0xFFFF
- err_timeout  out  1  sticky; cleared only by reset

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: all outputs 0, state IDLE, all counters 0. The dft_top instance shares the same reset.
  - Reset mid-frame aborts the frame immediately.
  - No m_valid or peak_valid is produced for the aborted frame.
- States:
  - IDLE -> FILL when run=1.
  - FILL: s_ready=1. Each accepted sample is written to buffer[wr_cnt]. When sample FFT_LEN-1 is accepted, go to ARM. s_valid gaps are tolerated.
  - ARM: one cycle with fft_next=1 and buffer read address 0 issued. Then go to FEED.
  - FEED: FFT_LEN/2 consecutive cycles, no gaps. Cycle k drives buffer[2k] and buffer[2k+1] on fft_x0 and fft_x2. The first data word is on the cycle directly after the fft_next pulse. Then go to WAIT.
  - WAIT: count cycles.
    - fft_next_out=1 -> DRAIN, starting on the next cycle.
    - Count reaches TIMEOUT -> set err_timeout and go to IDLE.
  - DRAIN: FFT_LEN/2 cycles. Cycle k registers fft_mag1/mag2, and m_bin=2k is presented one cycle later with m_valid=1. m_last accompanies k=FFT_LEN/2-1.
    - After the last pair: if run=1, go to FILL; otherwise go to IDLE.
- Peak tracker:
  - Peak search covers bins MIN_BIN..FFT_LEN/2-1 only. Higher bins are the mirror image for real input; they are still streamed but ignored.
  - Strict greater-than compare, so on a tie the lower bin index wins.
  - Within one pair, mag1 is compared before mag2.
  - peak_valid pulses one cycle after m_last. peak_bin and peak_mag hold until the next pulse. frame_cnt increments in the same cycle as peak_valid.
- Flow control:
  - s_ready=0 in every state except FILL, so samples arriving during FEED/WAIT/DRAIN are dropped by the source.
  - The FFT and m_* stream have no backpressure.
- run deasserted mid-frame: the current frame completes. run is sampled only at the end of DRAIN and in IDLE.
- Frame buffer: FFT_LEN x DATA_W, single port, synchronous read. Read latency is covered by the ARM cycle.

Optional Feature:
- Macro: FFT_WINDOW_EN.
- Defined:
  - A Hann coefficient ROM (FFT_LEN entries, unsigned Q1.15) multiplies each sample as it is read in FEED. The product is rounded half-up and truncated to DATA_W.
  - ARM becomes two cycles: cycle 1 issues the read, cycle 2 pulses fft_next. The FEED alignment relative to fft_next is unchanged.
- Undefined: samples pass unmodified and no ROM or multiplier is instantiated.

Decomposition:
- Shared package radar_dsp_pkg holds:
  - the state enum (IDLE, FILL, ARM, FEED, WAIT, DRAIN);
  - DATA_W;
  - the bin-index width function clog2(FFT_LEN);
  - the Hann ROM init constant.
- One sub-module: fft_peak_tracker (compare, hold, tie rule, MIN_BIN gating), driven by m_valid, m_bin, m_mag1, m_mag2 and m_last.

Test Plan:
- Tone: FFT_LEN=64, run=1, s_data=round(1000*cos(2*pi*5*n/64)).
  - fft_next is exactly one pulse per frame.
  - FEED runs 32 contiguous cycles after that pulse.
  - 32 m_valid pairs with m_bin 0,2,...,62.
  - peak_bin=5 and peak_valid pulses once; frame_cnt=1.
- DC plus tone: s_data=500+800*cos(2*pi*12*n/64), MIN_BIN=1 -> peak_bin=12 (the DC bin is excluded).
- Tie: FFT model returns equal magnitude 300 at bins 3 and 7, all others 0 -> peak_bin=3, peak_mag=300.
- Timeout: hold fft_next_out=0 after FEED, TIMEOUT=100.
  - err_timeout=1 at WAIT cycle 100, state returns to IDLE, no peak_valid.
  - err_timeout stays 1 until reset.
- Gappy input and back-to-back frames: s_valid toggles every other cycle and run is held high for 3 frames.
  - All 64 samples of each frame are captured; s_ready=0 outside FILL.
  - frame_cnt reaches 3.
  - Dropping run during frame 3 DRAIN ends in IDLE after m_last.
- Reset mid-FEED: assert reset at FEED cycle 10 -> all outputs 0 next cycle. A fresh frame afterwards completes normally with peak_bin correct.
